// File: rtl/seq_counter_bank_if.sv
// seq_counter_bank_if: control and status bundle for seq_counter_bank.
// master drives start/hold and observes the counter bank; slave is the engine.
interface seq_counter_bank_if #(
    parameter int W      = 8,
    parameter int NUM_CH = 4,
    parameter int NUM_ST = 3,
    parameter int ITER_W = 8
);
    localparam int ST_W = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;

    logic                    start;
    logic                    hold;
    logic [NUM_CH*W-1:0]     cnt;
    logic [ST_W-1:0]         st;
    logic [ITER_W-1:0]       iter;
    logic                    busy;
    logic                    done;

    modport master (
        output start, hold,
        input  cnt, st, iter, busy, done
    );

    modport slave (
        input  start, hold,
        output cnt, st, iter, busy, done
    );
endinterface

// File: rtl/seq_counter_bank.sv
// seq_counter_bank: cyclic program of NUM_ST states stepping a bank of NUM_CH
// W-bit counters; each state increments the channels set in its MASK slice.
// Runs ITER_MAX iterations then reports DONE (ITER_MAX=0: runs forever).
// Optional build macro SEQ_COUNTER_BANK_SAT_EN: counters saturate instead of wrapping.
module seq_counter_bank #(
    parameter int                          W        = 8,
    parameter int                          NUM_CH   = 4,
    parameter int                          NUM_ST   = 3,
    parameter logic [NUM_ST*NUM_CH-1:0]    MASK     = 12'b0001_1001_1100,
    parameter int                          ITER_W   = 8,
    parameter int                          ITER_MAX = 2
) (
    input  logic                clk,
    input  logic                rst,
    seq_counter_bank_if.slave   bus
);

    localparam int                 ST_W     = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;
    localparam logic [ST_W-1:0]    ST_LAST  = ST_W'(NUM_ST - 1);
    localparam logic [ITER_W-1:0]  ITER_LIM = ITER_W'(ITER_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state;
    logic [NUM_CH*W-1:0]    cnt_r;
    logic [NUM_CH*W-1:0]    cnt_inc;
    logic [ST_W-1:0]        st_r;
    logic [ITER_W-1:0]      iter_r;
    logic [ITER_W-1:0]      iter_inc;
    logic                   busy_r;
    logic                   done_r;
    logic [NUM_CH-1:0]      cur_mask;

    // Select the increment mask belonging to the current program state.
    always_comb begin
        cur_mask = '0;
        for (int unsigned s = 0; s < NUM_ST; s++) begin
            if (st_r == ST_W'(s)) begin
                cur_mask = MASK[s*NUM_CH +: NUM_CH];
            end
        end
    end

    // Candidate counter bank after one program step.
    always_comb begin
        cnt_inc = cnt_r;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (cur_mask[ch]) begin
`ifdef SEQ_COUNTER_BANK_SAT_EN
                if (cnt_r[ch*W +: W] != '1) begin
                    cnt_inc[ch*W +: W] = cnt_r[ch*W +: W] + W'(1);
                end
`else
                cnt_inc[ch*W +: W] = cnt_r[ch*W +: W] + W'(1);
`endif
            end
        end
    end

    assign iter_inc = iter_r + ITER_W'(1);

    // Top-level FSM with registered counters, program state and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt_r  <= '0;
            st_r   <= '0;
            iter_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state  <= S_RUN;
                        cnt_r  <= '0;
                        st_r   <= '0;
                        iter_r <= '0;
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!bus.hold) begin
                        cnt_r <= cnt_inc;
                        if (st_r == ST_LAST) begin
                            st_r   <= '0;
                            iter_r <= iter_inc;
                            if (ITER_MAX != 0 && iter_inc == ITER_LIM) begin
                                state  <= S_DONE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end
                        end else begin
                            st_r <= st_r + ST_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cnt  = cnt_r;
    assign bus.st   = st_r;
    assign bus.iter = iter_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_seq_counter_bank.sv
// tb_seq_counter_bank: directed checks of the default program, hold, restart,
// mid-run reset, 2-bit wrap/saturate and forever-mode instances.
module tb_seq_counter_bank;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_counter_bank_if #(.W(8), .NUM_CH(4), .NUM_ST(3), .ITER_W(8)) bd ();
    seq_counter_bank_if #(.W(2), .NUM_CH(1), .NUM_ST(1), .ITER_W(8)) bw ();
    seq_counter_bank_if #(.W(8), .NUM_CH(4), .NUM_ST(3), .ITER_W(2)) bf ();

    seq_counter_bank #(
        .W(8), .NUM_CH(4), .NUM_ST(3), .MASK(12'b0001_1001_1100),
        .ITER_W(8), .ITER_MAX(2)
    ) u_def (.clk(clk), .rst(rst), .bus(bd));

    seq_counter_bank #(
        .W(2), .NUM_CH(1), .NUM_ST(1), .MASK(1'b1),
        .ITER_W(8), .ITER_MAX(0)
    ) u_wrap (.clk(clk), .rst(rst), .bus(bw));

    seq_counter_bank #(
        .W(8), .NUM_CH(4), .NUM_ST(3), .MASK(12'b0001_1001_1100),
        .ITER_W(2), .ITER_MAX(0)
    ) u_fov (.clk(clk), .rst(rst), .bus(bf));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input int c0, input int c1, input int c2,
                         input int c3, input int s, input int it, input int b, input int d);
        chk({tag, ".cnt"},  64'(bd.cnt), 64'({8'(c3), 8'(c2), 8'(c1), 8'(c0)}));
        chk({tag, ".st"},   64'(bd.st),   64'(s));
        chk({tag, ".iter"}, 64'(bd.iter), 64'(it));
        chk({tag, ".busy"}, 64'(bd.busy), 64'(b));
        chk({tag, ".done"}, 64'(bd.done), 64'(d));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_w [5];

    initial begin
`ifdef SEQ_COUNTER_BANK_SAT_EN
        exp_w = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
        bd.start = 1'b0; bd.hold = 1'b0;
        bw.start = 1'b0; bw.hold = 1'b0;
        bf.start = 1'b0; bf.hold = 1'b0;

        // reset
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        chk_d("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.wrap.cnt", 64'(bw.cnt), 64'd0);
        chk("reset.fov.busy", 64'(bf.busy), 64'd0);

        // default program
        bd.start = 1'b1;
        tick;
        bd.start = 1'b0;
        chk_d("r1e0", 0, 0, 0, 0, 0, 0, 1, 0);
        tick; chk_d("r1e1", 0, 0, 1, 1, 1, 0, 1, 0);
        tick; chk_d("r1e2", 1, 0, 1, 2, 2, 0, 1, 0);
        tick; chk_d("r1e3", 2, 0, 1, 2, 0, 1, 1, 0);
        tick; chk_d("r1e4", 2, 0, 2, 3, 1, 1, 1, 0);
        tick; chk_d("r1e5", 3, 0, 2, 4, 2, 1, 1, 0);
        tick; chk_d("r1e6", 4, 0, 2, 4, 0, 2, 0, 1);
        tick; chk_d("done_keep", 4, 0, 2, 4, 0, 2, 0, 1);

        // restart from DONE, with hold and ignored start pulses in RUN
        bd.start = 1'b1;
        tick;
        bd.start = 1'b0;
        chk_d("restart", 0, 0, 0, 0, 0, 0, 1, 0);
        tick; chk_d("r2e1", 0, 0, 1, 1, 1, 0, 1, 0);
        tick; chk_d("r2e2", 1, 0, 1, 2, 2, 0, 1, 0);
        bd.hold = 1'b1;
        tick; chk_d("hold1", 1, 0, 1, 2, 2, 0, 1, 0);
        tick; chk_d("hold2", 1, 0, 1, 2, 2, 0, 1, 0);
        bd.hold = 1'b0;
        tick; chk_d("r2e3", 2, 0, 1, 2, 0, 1, 1, 0);
        bd.start = 1'b1;
        tick; chk_d("ign1", 2, 0, 2, 3, 1, 1, 1, 0);
        tick; chk_d("ign2", 3, 0, 2, 4, 2, 1, 1, 0);
        bd.start = 1'b0;
        tick; chk_d("r2e6", 4, 0, 2, 4, 0, 2, 0, 1);

        // mid-run reset, with start asserted alongside it
        bd.start = 1'b1;
        tick;
        bd.start = 1'b0;
        chk_d("r3e0", 0, 0, 0, 0, 0, 0, 1, 0);
        tick;
        tick; chk_d("r3e2", 1, 0, 1, 2, 2, 0, 1, 0);
        rst = 1'b1;
        bd.start = 1'b1;
        tick; chk_d("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        bd.start = 1'b0;
        tick;
        tick; chk_d("idle_quiet", 0, 0, 0, 0, 0, 0, 0, 0);

        // 2-bit single-channel wrap / saturate
        bw.start = 1'b1;
        tick;
        bw.start = 1'b0;
        chk("wrap.e0.cnt", 64'(bw.cnt), 64'd0);
        chk("wrap.e0.busy", 64'(bw.busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("wrap.cnt", 64'(bw.cnt), 64'(exp_w[i]));
            chk("wrap.iter", 64'(bw.iter), 64'(i + 1));
            chk("wrap.done", 64'(bw.done), 64'd0);
        end

        // forever mode with 2-bit iteration counter
        bf.start = 1'b1;
        tick;
        bf.start = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick;
            chk("fov.done", 64'(bf.done), 64'd0);
            chk("fov.busy", 64'(bf.busy), 64'd1);
            chk("fov.st", 64'(bf.st), 64'(cyc % 3));
            chk("fov.iter", 64'(bf.iter), 64'((cyc / 3) % 4));
        end
        chk("fov.cnt", 64'(bf.cnt), 64'({8'd10, 8'd5, 8'd0, 8'd10}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_counter_bank.md
# seq_counter_bank

Parametrised sequence engine driving a bank of `NUM_CH` counters, each `W` bits wide, through a cyclic program of `NUM_ST` states. Each state increments a compile-time subset of channels. It is the generalised successor of the fixed three-state, four-counter generated sequencer. The generalisation covers channel count, width, program length and iteration limit, and adds start/hold control and completion reporting. It sits under `top` as the canonical sequential regression block for the generator flow.

## Interface
Parameters:
- `W`, 8, counter width in bits.
- `NUM_CH`, 4, number of counter channels.
- `NUM_ST`, 3, number of program states per iteration (≥1).
- `MASK`, 12'b0001_1001_1100, increment masks, `NUM_ST*NUM_CH` bits. Bits `[s*NUM_CH +: NUM_CH]` are the mask for state `s`; bit `ch` set means channel `ch` increments in that state.
- `ITER_W`, 8, iteration counter width.
- `ITER_MAX`, 2, iterations before DONE; 0 means run forever.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a run; honoured only in IDLE or DONE.
- `hold` input 1: freeze the program (no advance, no increment) while high.
- `cnt` output `NUM_CH*W`: counter bank; channel `ch` is at `[ch*W +: W]`.
- `st` output `$clog2(NUM_ST)` (min 1): current program state index.
- `iter` output `ITER_W`: completed iterations.
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.

## Operation
- Top-level FSM has three states: IDLE, RUN and DONE.
- Reset gives IDLE, all counters 0, `st`=0, `iter`=0, `busy`=0, `done`=0.
- IDLE → RUN when `start`=1.
  - On that edge, counters, `st` and `iter` are cleared to 0.
- DONE → RUN when `start`=1, with the same clearing.
  - Without `start`, DONE persists and all outputs are held.
- RUN, with `hold`=0, on each edge:
  - Every channel with `MASK[st*NUM_CH+ch]`=1 increments by 1.
  - `st` advances to `(st+1) mod NUM_ST`.
- RUN with `hold`=1: nothing changes.
- End of iteration is the edge that advances `st` from `NUM_ST-1` to 0. On that edge `iter` increments.
  - If `ITER_MAX`≠0 and the new `iter` equals `ITER_MAX`: go to DONE, with `st` wrapped to 0.
  - That edge's increments still apply.
- `iter` wraps modulo 2^`ITER_W` when `ITER_MAX`=0.
- `start` in RUN is ignored.
- Counters wrap modulo 2^`W` (see Configuration).
- `rst` in any state, including mid-iteration, returns to the reset values on that edge. `rst` has priority over `start`.

## Timing
- Start latency:
  - `start` is sampled at edge E0.
  - `busy`=1 and `st`=0 are visible from E0.
  - The first increments (state 0 mask) are visible after E1.
- Each program state occupies exactly one cycle when `hold`=0. One iteration takes `NUM_ST` cycles.
- `hold` is sampled at the edge. Asserting `hold` for k cycles delays everything by exactly k cycles.
- `done` rises on the same edge as the final `iter` increment.
  - `busy` falls on that same edge.
  - `done` falls on the edge that accepts a restart `start`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SEQ_COUNTER_BANK_SAT_EN`:
  - Defined: each channel saturates at 2^`W`-1. An increment at max leaves the value unchanged.
  - Undefined (default): channels wrap from 2^`W`-1 to 0.
  - FSM, `st` and `iter` behaviour are identical in both builds.

## Test plan
Channels are written as (ch0, ch1, ch2, ch3).
- **Default program:** `rst` for 1 cycle, `start` pulse at E0.
  - After E1, E2, E3: (0,0,1,1), (1,0,1,2), (2,0,1,2).
  - After E4, E5, E6: (2,0,2,3), (3,0,2,4), (4,0,2,4).
  - `done`=1, `busy`=0 and `iter`=2 after E6.
- **Hold:** default program, `hold`=1 for the 2 cycles after E2.
  - Values stay (1,0,1,2) through those cycles.
  - Sequence resumes with (2,0,1,2) three cycles later; `done` is delayed by 2 cycles.
- **Restart and ignored start:**
  - `start` pulses during RUN cause no change.
  - `start` in DONE clears to (0,0,0,0), `iter`=0, `busy`=1.
  - The full default sequence then repeats.
- **Mid-run reset:** `rst` after E2 gives (0,0,0,0), IDLE, `st`=0, `iter`=0 on that edge. No activity until the next `start`.
- **Wrap vs saturate:** `W`=2, `NUM_CH`=1, `NUM_ST`=1, `MASK`=1, `ITER_MAX`=0, run 5 cycles.
  - Default build: ch0 sequence 1,2,3,0,1.
  - With `SEQ_COUNTER_BANK_SAT_EN`: 1,2,3,3,3.
- **Forever mode:** `ITER_MAX`=0, `ITER_W`=2, default mask, run 15 cycles.
  - `done` never asserts.
  - `iter` reads 1,2,3,0,1 at successive iteration boundaries.
